// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake and data bundle for alu_pipe.
//   Upstream side:   in_valid, in_ready, A, B, cntrl
//   Downstream side: out_valid, out_ready, result, negative, zero,
//                    overflow, carry_out
//   master modport - the environment (operand fetch / writeback)
//   slave modport  - the ALU itself
interface alu_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, A, B, cntrl, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, A, B, cntrl, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered WIDTH-bit ALU with valid/ready handshake on both sides.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset (discards any in-flight operation)
//   bus    - alu_pipe_if.slave: operands A/B, cntrl, handshakes, registered
//            result and flags (negative, zero, overflow, carry_out)
// cntrl: 000 PASS_B, 001 PASS_A, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR,
//        111 MUL (iterative shift-add, WIDTH cycles) when ALU_PIPE_MUL_EN is
//        defined; otherwise 111 behaves as PASS_B.
module alu_pipe #(
  parameter int WIDTH = 64
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_v_s;
  logic             alu_c_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             idle_s;
  logic             is_mul_s;
  logic             mul_wr_s;
  logic [WIDTH-1:0] mul_res_s;
  logic             mul_v_s;

  logic             out_valid_r, out_valid_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             negative_r, negative_s;
  logic             zero_r, zero_s;
  logic             overflow_r, overflow_s;
  logic             carry_out_r, carry_out_s;

`ifdef ALU_PIPE_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   count_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mplier_r;
  logic               last_s;

  assign idle_s    = (state_r == IDLE);
  assign is_mul_s  = (bus.cntrl == 3'b111);
  assign last_s    = (count_r == CNT_W'(WIDTH - 1));
  assign mul_wr_s  = (state_r == DONE) && (!out_valid_r || bus.out_ready);
  assign mul_res_s = acc_r[WIDTH-1:0];
  // Upper half of the full product nonzero means the low half lost bits.
  assign mul_v_s   = |acc_r[2*WIDTH-1:WIDTH];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_mul_s) state_s = MUL;
        else                      state_s = IDLE;
      end
      MUL: begin
        if (last_s) state_s = DONE;
        else        state_s = MUL;
      end
      DONE: begin
        if (mul_wr_s) state_s = IDLE;
        else          state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Shift-add multiplier datapath: one multiplier bit per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      acc_r    <= '0;
    end else if (accept_s && is_mul_s) begin
      count_r  <= '0;
      mcand_r  <= {{WIDTH{1'b0}}, bus.A};
      mplier_r <= bus.B;
      acc_r    <= '0;
    end else if (state_r == MUL) begin
      if (mplier_r[0]) acc_r <= acc_r + mcand_r;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + CNT_W'(1);
    end
  end
`else
  assign idle_s    = 1'b1;
  assign is_mul_s  = 1'b0;
  assign mul_wr_s  = 1'b0;
  assign mul_res_s = '0;
  assign mul_v_s   = 1'b0;
`endif

  assign in_ready_s   = idle_s && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && in_ready_s;
  assign bus.in_ready = in_ready_s;

  // SUB is A + ~B + 1, so carry_out = 1 means no borrow.
  assign sum_s  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_s = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

  // Single-cycle operation decode
  always_comb begin
    alu_res_s = bus.B;
    alu_v_s   = 1'b0;
    alu_c_s   = 1'b0;
    case (bus.cntrl)
      3'b000: alu_res_s = bus.B;
      3'b001: alu_res_s = bus.A;
      3'b010: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      3'b011: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      3'b100: alu_res_s = bus.A & bus.B;
      3'b101: alu_res_s = bus.A | bus.B;
      3'b110: alu_res_s = bus.A ^ bus.B;
      // 111 without the multiplier is PASS_B; with it this value is unused.
      default: alu_res_s = bus.B;
    endcase
  end

  // Output register next value: reload wins over consumption in the same cycle
  always_comb begin
    out_valid_s = out_valid_r;
    result_s    = result_r;
    negative_s  = negative_r;
    zero_s      = zero_r;
    overflow_s  = overflow_r;
    carry_out_s = carry_out_r;
    if (accept_s && !is_mul_s) begin
      out_valid_s = 1'b1;
      result_s    = alu_res_s;
      negative_s  = alu_res_s[WIDTH-1];
      zero_s      = (alu_res_s == '0);
      overflow_s  = alu_v_s;
      carry_out_s = alu_c_s;
    end else if (mul_wr_s) begin
      out_valid_s = 1'b1;
      result_s    = mul_res_s;
      negative_s  = mul_res_s[WIDTH-1];
      zero_s      = (mul_res_s == '0);
      overflow_s  = mul_v_s;
      carry_out_s = 1'b0;
    end else if (bus.out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= '0;
      negative_r  <= 1'b0;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      carry_out_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_s;
      result_r    <= result_s;
      negative_r  <= negative_s;
      zero_r      <= zero_s;
      overflow_r  <= overflow_s;
      carry_out_r <= carry_out_s;
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.negative  = negative_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;
  assign bus.carry_out = carry_out_r;

endmodule
